// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side packing stage.
package fifo_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } rd_pack_state_e;

    localparam int PACK_DEF = 4;

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a show-ahead FIFO read port and packs them into PACK-lane
// words on a valid/ready stream; a flush emits the partial word with a keep mask.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = PACK_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       rclk,
    input  logic                       rrst,
    input  logic                       rempty,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rinc,
    input  logic                       flush,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CNT_WIDTH-1:0]       word_cnt
);

    localparam int IDX_W = $clog2(PACK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK - 1);

    rd_pack_state_e                       state_r;
    logic [IDX_W-1:0]                     idx_r;
    logic [PACK-1:0][DATA_WIDTH-1:0]      acc_r;

    logic                                 out_free_s;
    logic                                 pop_s;
    logic [IDX_W-1:0]                     idx_nxt_s;
    logic                                 load_full_s;
    logic                                 load_part_s;
    logic [PACK-1:0][DATA_WIDTH-1:0]      full_word_s;
    logic [PACK-1:0][DATA_WIDTH-1:0]      part_word_s;
    logic [PACK-1:0]                      part_keep_s;

    // Pop decision: the last lane may only be popped when the output can take the word.
    always_comb begin
        out_free_s = !m_valid || m_ready;
        if (rrst) begin
            pop_s = 1'b0;
        end else if (state_r == FILL) begin
            pop_s = !rempty && ((idx_r != IDX_LAST) || out_free_s);
        end else begin
            pop_s = 1'b0;
        end
    end

    assign rinc        = pop_s;
    assign load_full_s = pop_s && (idx_r == IDX_LAST);
    assign load_part_s = (state_r == FLUSH) && out_free_s;

    // Lane index after this cycle's pop, used both for the update and the flush decision.
    always_comb begin
        if (pop_s) begin
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = '0;
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Candidate output words: full word takes the head byte in the top lane, partial zeroes unfilled lanes.
    always_comb begin
        full_word_s           = acc_r;
        full_word_s[PACK-1]   = rdata;
        part_word_s           = '0;
        part_keep_s           = '0;
        for (int i = 0; i < PACK; i++) begin
            if (i < int'(idx_r)) begin
                part_word_s[i] = acc_r[i];
                part_keep_s[i] = 1'b1;
            end else begin
                part_word_s[i] = {DATA_WIDTH{1'b0}};
                part_keep_s[i] = 1'b0;
            end
        end
    end

    // Accumulator, lane index and FILL/FLUSH control.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_r <= FILL;
            idx_r   <= '0;
            acc_r   <= '0;
        end else begin
            case (state_r)
                FILL: begin
                    if (pop_s && (idx_r != IDX_LAST)) begin
                        acc_r[idx_r] <= rdata;
                    end
                    idx_r <= idx_nxt_s;
                    // A pop completing a word leaves idx at 0, so that flush is dropped.
                    if (flush && (idx_nxt_s != '0)) begin
                        state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_free_s) begin
                        idx_r   <= '0;
                        state_r <= FILL;
                    end
                end
                default: begin
                    state_r <= FILL;
                    idx_r   <= '0;
                end
            endcase
        end
    end

    // Output word register: load beats accept, so load+accept gives back-to-back words.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            m_data  <= '0;
            m_keep  <= '0;
            m_valid <= 1'b0;
        end else if (load_full_s) begin
            m_data  <= full_word_s;
            m_keep  <= {PACK{1'b1}};
            m_valid <= 1'b1;
        end else if (load_part_s) begin
            m_data  <= part_word_s;
            m_keep  <= part_keep_s;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Accepted-word counter, wrapping naturally.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            word_cnt <= '0;
        end else if (m_valid && m_ready) begin
            word_cnt <= word_cnt + CNT_WIDTH'(1);
        end else begin
            word_cnt <= word_cnt;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Randomized self-checking bench for fifo_rd_packer against a queue-based model.
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int W  = DW * PK;

    logic          rclk;
    logic          rrst;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          flush;
    logic [W-1:0]  m_data;
    logic [PK-1:0] m_keep;
    logic          m_valid;
    logic          m_ready;
    logic [15:0]   word_cnt;

    logic          rinc_w;
    logic [W-1:0]  m_data_w;
    logic [PK-1:0] m_keep_w;
    logic          m_valid_w;
    logic [3:0]    word_cnt_w;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .CNT_WIDTH(16)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid),
        .m_ready(m_ready), .word_cnt(word_cnt)
    );

    // Narrow counter instance so counter wrap is reachable in a short run.
    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .CNT_WIDTH(4)) dut_w (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc_w),
        .flush(flush), .m_data(m_data_w), .m_keep(m_keep_w), .m_valid(m_valid_w),
        .m_ready(m_ready), .word_cnt(word_cnt_w)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int          nchk = 0;
    int          nfail = 0;

    // Behavioural model state
    logic [7:0]  src[$];
    logic [7:0]  part[$];
    bit          flushing_e;
    bit          mv_e;
    logic [W-1:0]  md_e;
    logic [PK-1:0] mk_e;
    int unsigned cnt_e;

    logic [W-1:0]  got_d[$];
    logic [PK-1:0] got_k[$];
    bit            last_rinc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        part.delete();
        flushing_e = 1'b0;
        mv_e       = 1'b0;
        md_e       = '0;
        mk_e       = '0;
        cnt_e      = 0;
    endtask

    task automatic step(input bit hide, input bit fl, input bit rdy);
        bit            out_free;
        bit            exp_rinc;
        bit            load;
        logic [W-1:0]  w;
        logic [PK-1:0] k;
        @(negedge rclk);
        rempty  = hide || (src.size() == 0);
        rdata   = rempty ? 8'($urandom) : src[0];
        flush   = fl;
        m_ready = rdy;
        #1;
        out_free = !mv_e || rdy;
        exp_rinc = !rempty && !flushing_e && ((part.size() != PK - 1) || out_free);
        chk("rinc", 64'(rinc), 64'(exp_rinc));
        chk("rinc_w", 64'(rinc_w), 64'(exp_rinc));
        chk("m_valid", 64'(m_valid), 64'(mv_e));
        chk("word_cnt", 64'(word_cnt), 64'(cnt_e[15:0]));
        chk("word_cnt_w", 64'(word_cnt_w), 64'(cnt_e[3:0]));
        if (mv_e) begin
            chk("m_data", 64'(m_data), 64'(md_e));
            chk("m_keep", 64'(m_keep), 64'(mk_e));
        end
        last_rinc = rinc;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_k.push_back(m_keep);
        end
        // Model next state from the byte-stream rules.
        load = 1'b0;
        w    = '0;
        k    = '0;
        if (!flushing_e) begin
            if (exp_rinc) begin
                part.push_back(rdata);
                if (part.size() == PK) begin
                    foreach (part[i]) w[i*DW +: DW] = part[i];
                    k    = '1;
                    load = 1'b1;
                    part.delete();
                end
            end
            if (fl && part.size() > 0) flushing_e = 1'b1;
        end else if (out_free) begin
            foreach (part[i]) w[i*DW +: DW] = part[i];
            k          = PK'((1 << part.size()) - 1);
            load       = 1'b1;
            part.delete();
            flushing_e = 1'b0;
        end
        if (mv_e && rdy) cnt_e++;
        if (load) begin
            md_e = w;
            mk_e = k;
            mv_e = 1'b1;
        end else if (rdy) begin
            mv_e = 1'b0;
        end
        if (exp_rinc) void'(src.pop_front());
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst    = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        rempty  = 1'b1;
        #1;
        chk("rst_rinc", 64'(rinc), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_keep", 64'(m_keep), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_word_cnt_w", 64'(word_cnt_w), 64'd0);
        model_reset();
        src.delete();
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    task automatic chk_words(input string nm, input logic [W-1:0] ew[$], input logic [PK-1:0] ek[$]);
        chk({nm, "_count"}, 64'(got_d.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size() && i < got_d.size(); i++) begin
            chk({nm, "_data"}, 64'(got_d[i]), 64'(ew[i]));
            chk({nm, "_keep"}, 64'(got_k[i]), 64'(ek[i]));
        end
        got_d.delete();
        got_k.delete();
    endtask

    initial begin
        int rinc_cnt;
        int c0;
        rrst    = 1'b1;
        rempty  = 1'b1;
        rdata   = '0;
        flush   = 1'b0;
        m_ready = 1'b0;
        model_reset();
        do_reset();

        // Sixteen bytes streamed with consumer always ready.
        for (int i = 0; i < 16; i++) src.push_back(8'(i));
        rinc_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (last_rinc) rinc_cnt++;
        end
        chk("stream_rinc_cycles", 64'(rinc_cnt), 64'd16);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);
        chk_words("stream", '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C},
                  '{4'hF, 4'hF, 4'hF, 4'hF});
        chk("stream_word_cnt", 64'(word_cnt), 64'd4);

        // Output stall: last lane waits, word held stable.
        for (int i = 0; i < 8; i++) src.push_back(8'(i));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        chk("stall_rinc", 64'(last_rinc), 64'd0);
        chk("stall_m_valid", 64'(m_valid), 64'd1);
        chk("stall_m_data", 64'(m_data), 64'h03020100);
        chk("stall_src_left", 64'(src.size()), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        chk_words("stall", '{32'h03020100, 32'h07060504}, '{4'hF, 4'hF});

        // Partial flush, then the next byte lands in lane 0.
        src.push_back(8'hAA); src.push_back(8'hBB); src.push_back(8'hCC);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);
        src.push_back(8'hDD);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        chk_words("flush", '{32'h00CCBBAA, 32'h000000DD}, '{4'b0111, 4'b0001});

        // Flush at idx 0 and flush on the completing pop add nothing.
        c0 = int'(word_cnt);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) src.push_back(8'h40 + 8'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        chk_words("noflush", '{32'h43424140}, '{4'hF});
        chk("noflush_cnt_delta", 64'(int'(word_cnt) - c0), 64'd1);

        // Reset with a pending word and two lanes filled.
        for (int i = 0; i < 6; i++) src.push_back(8'h50 + 8'(i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
        chk("pre_rst_m_valid", 64'(m_valid), 64'd1);
        do_reset();
        got_d.delete(); got_k.delete();
        for (int i = 0; i < 4; i++) src.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
        chk_words("post_rst", '{32'h13121110}, '{4'hF});

        // Counter wrap on the narrow instance: 17 words -> 1.
        do_reset();
        for (int i = 0; i < 68; i++) src.push_back(8'($urandom));
        for (int i = 0; i < 72; i++) step(1'b0, 1'b0, 1'b1);
        chk("wrap_cnt_w", 64'(word_cnt_w), 64'd1);
        chk("wrap_cnt", 64'(word_cnt), 64'd17);
        got_d.delete(); got_k.delete();

        // Randomized traffic with a mid-run reset.
        for (int i = 0; i < 4000; i++) begin
            bit hide;
            bit fl;
            bit rdy;
            if (i == 2000) do_reset();
            if (src.size() < 8) begin
                int n = $urandom_range(0, 6);
                for (int j = 0; j < n; j++) src.push_back(8'($urandom));
            end
            hide = ($urandom_range(0, 3) == 0);
            fl   = ($urandom_range(0, 7) == 0);
            if (((i / 500) % 2) == 1) rdy = ($urandom_range(0, 9) < 3);
            else                      rdy = ($urandom_range(0, 9) < 8);
            step(hide, fl, rdy);
        end
        got_d.delete(); got_k.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
